// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multi-cycle RV32I control unit (FETCH/EXEC/WAIT/WB).
// Data-memory read latency is set by MEM_LAT (1..15 cycles).
// Optional interrupt entry state is built only when MCYCLE_CTRL_INTR_EN is defined.
module mcycle_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IR,
   input  logic        BR_EQ,
   input  logic        BR_LT,
   input  logic        BR_LTU,
   output logic        MEM_RDEN1,
   output logic        MEM_RDEN2,
   output logic        MEM_WE2,
   output logic        PC_WE,
   output logic        REG_WE,
   output logic [2:0]  IMM_SEL,
   output logic [2:0]  PC_SEL,
   output logic [3:0]  ALU_FUN,
   output logic        SRCA_SEL,
   output logic [1:0]  SRCB_SEL,
   output logic [1:0]  RF_WR_SEL,
   output logic [2:0]  STATE,
   output logic        ILLEGAL
`ifdef MCYCLE_CTRL_INTR_EN
   ,
   input  logic        INTR,
   output logic        INT_TAKEN
`endif
);

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXEC  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WB    = 3'd3,
      ST_INTR  = 3'd4
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [3:0] LOAD_CNT = 4'(MEM_LAT - 1);

   state_t      state;
   state_t      next_state;
   logic [3:0]  cnt;
   logic [3:0]  cnt_next;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
   logic        is_load, is_store, is_opimm, is_op, is_known;
   logic        branch_taken;
   logic        irq_req;
   logic [2:0]  dec_imm_sel;
   logic [3:0]  dec_alu_fun;
   logic        dec_srca_sel;
   logic [1:0]  dec_srcb_sel;
   logic        unused_ir;

   assign opcode    = IR[6:0];
   assign funct3    = IR[14:12];
   assign unused_ir = ^{IR[31], IR[29:15], IR[11:7]};

   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_op     = (opcode == OPC_OP);
   assign is_known  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                      is_load | is_store | is_opimm | is_op;

`ifdef MCYCLE_CTRL_INTR_EN
   assign irq_req = INTR;
`else
   assign irq_req = 1'b0;
`endif

   assign STATE = state;

   // State register and load-latency counter; reset wins over any transition.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_FETCH;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   // Branch condition select from funct3; 010/011 are not valid branches.
   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'b000:  branch_taken = BR_EQ;
         3'b001:  branch_taken = ~BR_EQ;
         3'b100:  branch_taken = BR_LT;
         3'b101:  branch_taken = ~BR_LT;
         3'b110:  branch_taken = BR_LTU;
         3'b111:  branch_taken = ~BR_LTU;
         default: branch_taken = 1'b0;
      endcase
   end

   // Instruction-field decode shared by EXEC, WAIT and WB.
   always_comb begin
      dec_imm_sel  = 3'd0;
      dec_alu_fun  = 4'b0000;
      dec_srca_sel = 1'b0;
      dec_srcb_sel = 2'd0;
      if (is_lui) begin
         dec_imm_sel  = 3'd3;
         dec_alu_fun  = 4'b1001;
         dec_srca_sel = 1'b1;
      end else if (is_auipc) begin
         dec_imm_sel  = 3'd3;
         dec_srca_sel = 1'b1;
         dec_srcb_sel = 2'd2;
      end else if (is_jal) begin
         dec_imm_sel  = 3'd4;
      end else if (is_jalr || is_load) begin
         dec_srcb_sel = 2'd1;
      end else if (is_store) begin
         dec_imm_sel  = 3'd1;
         dec_srcb_sel = 2'd1;
      end else if (is_branch) begin
         dec_imm_sel  = 3'd2;
      end else if (is_opimm) begin
         dec_alu_fun  = {(funct3 == 3'b101) ? IR[30] : 1'b0, funct3};
         dec_srcb_sel = 2'd1;
      end else if (is_op) begin
         dec_alu_fun  = {IR[30], funct3};
      end
   end

   // Next-state and output decode; every enable defaults low.
   always_comb begin
      next_state = ST_FETCH;
      cnt_next   = cnt;
      MEM_RDEN1  = 1'b0;
      MEM_RDEN2  = 1'b0;
      MEM_WE2    = 1'b0;
      PC_WE      = 1'b0;
      REG_WE     = 1'b0;
      IMM_SEL    = 3'd0;
      PC_SEL     = 3'd0;
      ALU_FUN    = 4'b0000;
      SRCA_SEL   = 1'b0;
      SRCB_SEL   = 2'd0;
      RF_WR_SEL  = 2'd0;
      ILLEGAL    = 1'b0;
`ifdef MCYCLE_CTRL_INTR_EN
      INT_TAKEN  = 1'b0;
`endif
      case (state)
         ST_FETCH: begin
            MEM_RDEN1  = 1'b1;
            next_state = ST_EXEC;
         end
         ST_EXEC: begin
            IMM_SEL  = dec_imm_sel;
            ALU_FUN  = dec_alu_fun;
            SRCA_SEL = dec_srca_sel;
            SRCB_SEL = dec_srcb_sel;
            if (is_load) begin
               MEM_RDEN2  = 1'b1;
               RF_WR_SEL  = 2'd2;
               cnt_next   = LOAD_CNT;
               next_state = (MEM_LAT == 1) ? ST_WB : ST_WAIT;
            end else begin
               PC_WE      = 1'b1;
               RF_WR_SEL  = (is_jal || is_jalr) ? 2'd0 : 2'd2;
               REG_WE     = is_lui | is_auipc | is_jal | is_jalr | is_op | is_opimm;
               MEM_WE2    = is_store;
               ILLEGAL    = ~is_known;
               if (is_jal)
                  PC_SEL = 3'd3;
               else if (is_jalr)
                  PC_SEL = 3'd1;
               else if (is_branch && branch_taken)
                  PC_SEL = 3'd2;
               next_state = irq_req ? ST_INTR : ST_FETCH;
            end
         end
         ST_WAIT: begin
            IMM_SEL    = dec_imm_sel;
            ALU_FUN    = dec_alu_fun;
            SRCA_SEL   = dec_srca_sel;
            SRCB_SEL   = dec_srcb_sel;
            RF_WR_SEL  = 2'd1;
            MEM_RDEN2  = 1'b1;
            cnt_next   = cnt - 4'd1;
            next_state = (cnt <= 4'd1) ? ST_WB : ST_WAIT;
         end
         ST_WB: begin
            IMM_SEL    = dec_imm_sel;
            ALU_FUN    = dec_alu_fun;
            SRCA_SEL   = dec_srca_sel;
            SRCB_SEL   = dec_srcb_sel;
            REG_WE     = 1'b1;
            RF_WR_SEL  = 2'd1;
            PC_WE      = 1'b1;
            next_state = irq_req ? ST_INTR : ST_FETCH;
         end
`ifdef MCYCLE_CTRL_INTR_EN
         ST_INTR: begin
            PC_SEL     = 3'd4;
            PC_WE      = 1'b1;
            INT_TAKEN  = 1'b1;
            next_state = ST_FETCH;
         end
`endif
         default: begin
            next_state = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: directed, table-driven bench for mcycle_ctrl (MEM_LAT=3).
// Interrupt sequences are included when MCYCLE_CTRL_INTR_EN is defined.
module tb_mcycle_ctrl;

   localparam int LAT = 3;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] IR;
   logic        BR_EQ, BR_LT, BR_LTU;
   logic        MEM_RDEN1, MEM_RDEN2, MEM_WE2, PC_WE, REG_WE;
   logic [2:0]  IMM_SEL, PC_SEL, STATE;
   logic [3:0]  ALU_FUN;
   logic        SRCA_SEL;
   logic [1:0]  SRCB_SEL, RF_WR_SEL;
   logic        ILLEGAL;
`ifdef MCYCLE_CTRL_INTR_EN
   logic        INTR;
   logic        INT_TAKEN;
`endif

   int check_count = 0;
   int pass_count  = 0;

   typedef struct {
      string       name;
      logic [31:0] ir;
      logic        br_eq, br_lt, br_ltu;
      logic [2:0]  imm_sel;
      logic [2:0]  pc_sel;
      logic [3:0]  alu_fun;
      logic [1:0]  rf_wr_sel;
      logic        reg_we;
      logic        mem_we2;
      logic        illegal;
   } vec_t;

   vec_t vecs[$];

   mcycle_ctrl #(.MEM_LAT(LAT)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IR        (IR),
      .BR_EQ     (BR_EQ),
      .BR_LT     (BR_LT),
      .BR_LTU    (BR_LTU),
      .MEM_RDEN1 (MEM_RDEN1),
      .MEM_RDEN2 (MEM_RDEN2),
      .MEM_WE2   (MEM_WE2),
      .PC_WE     (PC_WE),
      .REG_WE    (REG_WE),
      .IMM_SEL   (IMM_SEL),
      .PC_SEL    (PC_SEL),
      .ALU_FUN   (ALU_FUN),
      .SRCA_SEL  (SRCA_SEL),
      .SRCB_SEL  (SRCB_SEL),
      .RF_WR_SEL (RF_WR_SEL),
      .STATE     (STATE),
      .ILLEGAL   (ILLEGAL)
`ifdef MCYCLE_CTRL_INTR_EN
      ,
      .INTR      (INTR),
      .INT_TAKEN (INT_TAKEN)
`endif
   );

   // Free-running 10-unit clock.
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected)
         pass_count++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] ir, input logic eq, input logic lt, input logic ltu);
      IR     = ir;
      BR_EQ  = eq;
      BR_LT  = lt;
      BR_LTU = ltu;
   endtask

   task automatic checkFetch(input string tag);
      checkOutput({tag, " fetch STATE"}, 32'(STATE), 32'd0);
      checkOutput({tag, " fetch RDEN1"}, 32'(MEM_RDEN1), 32'd1);
      checkOutput({tag, " fetch enables"}, 32'({MEM_RDEN2, MEM_WE2, PC_WE, REG_WE, ILLEGAL}), 32'd0);
      checkOutput({tag, " fetch sel"}, 32'({IMM_SEL, PC_SEL}), 32'd0);
   endtask

   function automatic vec_t makeVec(input string name, input logic [31:0] ir,
                                    input logic eq, input logic lt, input logic ltu,
                                    input logic [2:0] imm_sel, input logic [2:0] pc_sel,
                                    input logic [3:0] alu_fun, input logic [1:0] rf_wr_sel,
                                    input logic reg_we, input logic mem_we2, input logic illegal);
      vec_t v;
      v.name      = name;
      v.ir        = ir;
      v.br_eq     = eq;
      v.br_lt     = lt;
      v.br_ltu    = ltu;
      v.imm_sel   = imm_sel;
      v.pc_sel    = pc_sel;
      v.alu_fun   = alu_fun;
      v.rf_wr_sel = rf_wr_sel;
      v.reg_we    = reg_we;
      v.mem_we2   = mem_we2;
      v.illegal   = illegal;
      return v;
   endfunction

   // Directed test sequence.
   initial begin
      //                     name        IR            eq lt ltu imm pc alu      rf reg we2 ill
      vecs.push_back(makeVec("addi",  32'h00500093, 0, 0, 0, 3'd0, 3'd0, 4'b0000, 2'd2, 1, 0, 0));
      vecs.push_back(makeVec("beq_t", 32'h00208463, 1, 0, 0, 3'd2, 3'd2, 4'b0000, 2'd2, 0, 0, 0));
      vecs.push_back(makeVec("beq_n", 32'h00208463, 0, 0, 0, 3'd2, 3'd0, 4'b0000, 2'd2, 0, 0, 0));
      vecs.push_back(makeVec("bne_t", 32'h00209463, 0, 0, 0, 3'd2, 3'd2, 4'b0000, 2'd2, 0, 0, 0));
      vecs.push_back(makeVec("blt_t", 32'h0020C463, 0, 1, 0, 3'd2, 3'd2, 4'b0000, 2'd2, 0, 0, 0));
      vecs.push_back(makeVec("bge_n", 32'h0020D463, 0, 1, 0, 3'd2, 3'd0, 4'b0000, 2'd2, 0, 0, 0));
      vecs.push_back(makeVec("bltu_t",32'h0020E463, 0, 0, 1, 3'd2, 3'd2, 4'b0000, 2'd2, 0, 0, 0));
      vecs.push_back(makeVec("bgeu_t",32'h0020F463, 0, 0, 0, 3'd2, 3'd2, 4'b0000, 2'd2, 0, 0, 0));
      vecs.push_back(makeVec("br010", 32'h0020A463, 1, 1, 1, 3'd2, 3'd0, 4'b0000, 2'd2, 0, 0, 0));
      vecs.push_back(makeVec("sw",    32'h0020A023, 0, 0, 0, 3'd1, 3'd0, 4'b0000, 2'd2, 0, 1, 0));
      vecs.push_back(makeVec("ill_ff",32'hFFFFFFFF, 0, 0, 0, 3'd0, 3'd0, 4'b0000, 2'd2, 0, 0, 1));
      vecs.push_back(makeVec("fence", 32'h0000000F, 0, 0, 0, 3'd0, 3'd0, 4'b0000, 2'd2, 0, 0, 1));
      vecs.push_back(makeVec("lui",   32'h123450B7, 0, 0, 0, 3'd3, 3'd0, 4'b1001, 2'd2, 1, 0, 0));
      vecs.push_back(makeVec("auipc", 32'h00001117, 0, 0, 0, 3'd3, 3'd0, 4'b0000, 2'd2, 1, 0, 0));
      vecs.push_back(makeVec("jal",   32'h008000EF, 0, 0, 0, 3'd4, 3'd3, 4'b0000, 2'd0, 1, 0, 0));
      vecs.push_back(makeVec("jalr",  32'h000080E7, 0, 0, 0, 3'd0, 3'd1, 4'b0000, 2'd0, 1, 0, 0));
      vecs.push_back(makeVec("sub",   32'h402081B3, 0, 0, 0, 3'd0, 3'd0, 4'b1000, 2'd2, 1, 0, 0));
      vecs.push_back(makeVec("srai",  32'h4020D193, 0, 0, 0, 3'd0, 3'd0, 4'b1101, 2'd2, 1, 0, 0));
      vecs.push_back(makeVec("xori30",32'h4000C093, 0, 0, 0, 3'd0, 3'd0, 4'b0100, 2'd2, 1, 0, 0));

      RST = 1'b1;
      applyStimulus(32'h0, 0, 0, 0);
`ifdef MCYCLE_CTRL_INTR_EN
      INTR = 1'b0;
`endif

      step();
      checkFetch("rst1");
      step();
      checkFetch("rst2");
      RST = 1'b0;
      #1;
      checkFetch("post_rst");

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ir, vecs[i].br_eq, vecs[i].br_lt, vecs[i].br_ltu);
         step();
         checkOutput({vecs[i].name, " STATE"},     32'(STATE),     32'd1);
         checkOutput({vecs[i].name, " IMM_SEL"},   32'(IMM_SEL),   32'(vecs[i].imm_sel));
         checkOutput({vecs[i].name, " PC_SEL"},    32'(PC_SEL),    32'(vecs[i].pc_sel));
         checkOutput({vecs[i].name, " ALU_FUN"},   32'(ALU_FUN),   32'(vecs[i].alu_fun));
         checkOutput({vecs[i].name, " RF_WR_SEL"}, 32'(RF_WR_SEL), 32'(vecs[i].rf_wr_sel));
         checkOutput({vecs[i].name, " REG_WE"},    32'(REG_WE),    32'(vecs[i].reg_we));
         checkOutput({vecs[i].name, " MEM_WE2"},   32'(MEM_WE2),   32'(vecs[i].mem_we2));
         checkOutput({vecs[i].name, " ILLEGAL"},   32'(ILLEGAL),   32'(vecs[i].illegal));
         checkOutput({vecs[i].name, " PC_WE"},     32'(PC_WE),     32'd1);
         checkOutput({vecs[i].name, " RDEN"},      32'({MEM_RDEN1, MEM_RDEN2}), 32'd0);
         step();
         checkFetch(vecs[i].name);
      end

      // Load with three-cycle memory latency: EXEC, WAIT x2, WB, FETCH.
      applyStimulus(32'h0000A103, 0, 0, 0);
      step();
      checkOutput("lw exec STATE", 32'(STATE), 32'd1);
      checkOutput("lw exec en", 32'({MEM_RDEN2, PC_WE, REG_WE}), 32'b100);
      for (int w = 0; w < LAT - 1; w++) begin
         step();
         checkOutput($sformatf("lw wait%0d STATE", w), 32'(STATE), 32'd2);
         checkOutput($sformatf("lw wait%0d en", w), 32'({MEM_RDEN2, PC_WE, REG_WE}), 32'b100);
      end
      step();
      checkOutput("lw wb STATE", 32'(STATE), 32'd3);
      checkOutput("lw wb en", 32'({MEM_RDEN2, PC_WE, REG_WE}), 32'b011);
      checkOutput("lw wb RF_WR_SEL", 32'(RF_WR_SEL), 32'd1);
      step();
      checkFetch("lw_done");

      // Reset asserted mid-WAIT must abort the load without a register write.
      applyStimulus(32'h0000A103, 0, 0, 0);
      step();
      step();
      checkOutput("rstwait pre STATE", 32'(STATE), 32'd2);
      checkOutput("rstwait pre REG_WE", 32'(REG_WE), 32'd0);
      RST = 1'b1;
      step();
      checkOutput("rstwait STATE", 32'(STATE), 32'd0);
      checkOutput("rstwait RDEN2", 32'(MEM_RDEN2), 32'd0);
      checkOutput("rstwait REG_WE", 32'(REG_WE), 32'd0);
      RST = 1'b0;
      step();
      checkOutput("rstwait after STATE", 32'(STATE), 32'd1);
      checkOutput("rstwait after REG_WE", 32'(REG_WE), 32'd0);
      step();
      checkOutput("rstwait after2 STATE", 32'(STATE), 32'd2);
      RST = 1'b1;
      step();
      RST = 1'b0;
      checkFetch("rstwait_end");

`ifdef MCYCLE_CTRL_INTR_EN
      // Interrupt taken at completion of addi: EXEC -> INTR -> FETCH.
      applyStimulus(32'h00500093, 0, 0, 0);
      step();
      INTR = 1'b1;
      #1;
      checkOutput("irq exec STATE", 32'(STATE), 32'd1);
      checkOutput("irq exec PC_WE", 32'(PC_WE), 32'd1);
      step();
      INTR = 1'b0;
      checkOutput("irq STATE", 32'(STATE), 32'd4);
      checkOutput("irq PC_SEL", 32'(PC_SEL), 32'd4);
      checkOutput("irq INT_TAKEN", 32'(INT_TAKEN), 32'd1);
      checkOutput("irq PC_WE", 32'(PC_WE), 32'd1);
      step();
      checkFetch("irq_done");
      checkOutput("irq done INT_TAKEN", 32'(INT_TAKEN), 32'd0);
      // Interrupt raised during FETCH is ignored.
      INTR = 1'b1;
      step();
      INTR = 1'b0;
      checkOutput("irq fetch ignored STATE", 32'(STATE), 32'd1);
      step();
      checkFetch("irq_fetch");
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
